spi_reg_bank: RTL

- Parametrised SPI-slave register bank; successor to the fixed colour/misc SPI receiver.
- Holds NUM_REGS registers of REG_WIDTH bits each.
- Decodes a command byte carrying R/W flag and address, then supports burst write/read with address auto-increment.
- Sits between the external SPI pins and the shader/sprite datapath. Registers are exported flat; a write strobe lets consumers react to updates.

---
 rtl/spi_reg_bank.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: parametrised SPI-slave register bank (mode 0, MSB first).
//
// A command byte {write_flag, start_addr[6:0]} opens each frame. Data words
// of REG_WIDTH bits follow. The address auto-increments after every word and
// wraps to 0 after NUM_REGS-1.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   spi_sclk   SPI clock, asynchronous to clk (at most clk/4)
//   spi_mosi   SPI data in
//   spi_cs     chip select, active low
//   spi_miso   SPI data out, updated on SCLK falling edges
//   regs       flat register contents, register i at [i*REG_WIDTH +: REG_WIDTH]
//   wr_strobe  one-cycle pulse after a register is committed
//   wr_addr    address of the committed register, valid with wr_strobe
//   busy       high while synchronized chip select is low
//
// Build option: define SPI_REG_BANK_READBACK_EN to drive register data on
// spi_miso during read commands. Without it, no tx shifter is built and
// spi_miso is tied low.
//
// state   | meaning
// ST_CMD  | shifting in the 8-bit command byte
// ST_DATA | shifting data words, auto-incrementing addr per word

module spi_reg_bank #(
  parameter int NUM_REGS = 8,
  parameter int REG_WIDTH = 8,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUES = '0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs,
  output logic                          spi_miso,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs,
  output logic                          wr_strobe,
  output logic [6:0]                    wr_addr,
  output logic                          busy
);

  typedef enum logic {ST_CMD, ST_DATA} state_t;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(REG_WIDTH - 1);
  localparam logic [6:0] ADDR_LAST = 7'(NUM_REGS - 1);

  logic [SYNC_STAGES-1:0]        sclk_sync, mosi_sync, cs_sync;
  logic                          sclk_d;
  logic                          sclk_s, mosi_s, cs_s;
  logic                          sclk_rise, sclk_fall;
  state_t                        state;
  logic [CNT_W-1:0]              bit_cnt;
  logic [7:0]                    cmd;
  logic [7:0]                    cmd_next;
  logic [REG_WIDTH-1:0]          rx;
  logic [REG_WIDTH-1:0]          rx_next;
  logic [6:0]                    addr;
  logic [6:0]                    addr_inc;
  logic                          addr_in_range;
  logic                          wr_mode;
  logic [NUM_REGS*REG_WIDTH-1:0] regs_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // Edges are only meaningful inside a frame.
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;

  assign cmd_next      = {cmd[6:0], mosi_s};
  // Word including the bit sampled on this edge, so the commit is complete.
  assign rx_next       = REG_WIDTH'({rx, mosi_s});
  assign addr_inc      = (addr == ADDR_LAST) ? 7'd0 : addr + 7'd1;
  assign addr_in_range = int'(addr) < NUM_REGS;

  assign regs = regs_q;
  assign busy = ~cs_s;

`ifdef SPI_REG_BANK_READBACK_EN
  logic [REG_WIDTH-1:0] tx;
  logic [REG_WIDTH-1:0] tx_cmd;
  logic [REG_WIDTH-1:0] tx_inc;
  logic                 miso_q;

  function automatic logic [REG_WIDTH-1:0] read_word(input logic [6:0] a);
    if (int'(a) < NUM_REGS) return regs_q[int'(a)*REG_WIDTH +: REG_WIDTH];
    return '0;
  endfunction

  assign tx_cmd   = read_word(cmd_next[6:0]);
  assign tx_inc   = read_word(addr_inc);
  assign spi_miso = miso_q;
`else
  assign spi_miso = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      state     <= ST_CMD;
      bit_cnt   <= '0;
      cmd       <= '0;
      rx        <= '0;
      addr      <= '0;
      wr_mode   <= 1'b0;
      regs_q    <= RESET_VALUES;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
`ifdef SPI_REG_BANK_READBACK_EN
      tx        <= '0;
      miso_q    <= 1'b0;
`endif
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_d    <= sclk_s;
      wr_strobe <= 1'b0;

      // A high cs outranks any coincident edge, so a final bit arriving
      // together with cs rising never commits.
      if (cs_s) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        case (state)
          ST_CMD: begin
            cmd <= cmd_next;
            if (bit_cnt == CMD_LAST) begin
              addr    <= cmd_next[6:0];
              wr_mode <= cmd_next[7];
              bit_cnt <= '0;
              state   <= ST_DATA;
`ifdef SPI_REG_BANK_READBACK_EN
              tx      <= tx_cmd;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            rx <= rx_next;
            if (bit_cnt == WORD_LAST) begin
              if (wr_mode && addr_in_range) begin
                regs_q[int'(addr)*REG_WIDTH +: REG_WIDTH] <= rx_next;
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
              end
              addr    <= addr_inc;
              bit_cnt <= '0;
`ifdef SPI_REG_BANK_READBACK_EN
              tx      <= tx_inc;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= ST_CMD;
        endcase
      end
`ifdef SPI_REG_BANK_READBACK_EN
      else if (sclk_fall && state == ST_DATA) begin
        miso_q <= tx[REG_WIDTH-1];
        tx     <= REG_WIDTH'({tx, 1'b0});
      end
`endif
    end
  end

endmodule
